// File: rtl/egress_dest_queue.sv
// Egress queue behind the header sorter: captures header+dest then payload into one in-order FIFO.
// Optional macro EGRESS_ERR_DROP_EN drops error-sink entries and counts them instead of queueing.
module egress_dest_queue #(
    parameter int DEPTH       = 8,
    parameter int LINK_NUMBER = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [95:0]              in_header,
    input  logic [2:0]               in_dest,
    input  logic [31:0]              in_payload,
    output logic                     next_ready,
    output logic                     out_valid,
    output logic [95:0]              out_header,
    output logic [31:0]              out_payload,
    output logic [1:0]               out_dest,
    output logic [2:0]               out_link,
    input  logic [3:0]               dest_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overrun,
    output logic [7:0]               drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {IDLE, WAIT_PAYLOAD} state_t;

    state_t          state_q, state_d;
    logic [95:0]     hdr_q, hdr_d;
    logic [1:0]      dest_q, dest_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            overrun_q;

    logic [95:0]     hdr_mem [DEPTH];
    logic [31:0]     pay_mem [DEPTH];
    logic [1:0]      dst_mem [DEPTH];

    logic            hdr_beat, drop_entry, push, pop;
    logic [1:0]      dest_map;

    assign hdr_beat   = (in_header != '0);
    // Codes 4-7 and 0 all fall into the error sink.
    assign dest_map   = in_dest[2] ? 2'd0 : in_dest[1:0];
    assign next_ready = (state_q == IDLE) && (count_q < CW'(DEPTH));

`ifdef EGRESS_ERR_DROP_EN
    logic [7:0] drop_cnt_q;
    assign drop_entry = (dest_q == 2'd0);
    assign drop_count = drop_cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            drop_cnt_q <= '0;
        else if (state_q == WAIT_PAYLOAD && drop_entry && drop_cnt_q != 8'hFF)
            drop_cnt_q <= drop_cnt_q + 8'd1;
    end
`else
    assign drop_entry = 1'b0;
    assign drop_count = '0;
`endif

    assign push = (state_q == WAIT_PAYLOAD) && !drop_entry;

    assign out_valid   = (count_q != '0);
    assign out_header  = out_valid ? hdr_mem[rd_ptr_q] : '0;
    assign out_payload = out_valid ? pay_mem[rd_ptr_q] : '0;
    assign out_dest    = out_valid ? dst_mem[rd_ptr_q] : '0;
    assign out_link    = 3'(LINK_NUMBER);
    assign pop         = out_valid && dest_ready[out_dest];

    assign fifo_count = count_q;
    assign overrun    = overrun_q;

    always_comb begin
        state_d = state_q;
        hdr_d   = hdr_q;
        dest_d  = dest_q;
        case (state_q)
            IDLE: begin
                if (hdr_beat && next_ready) begin
                    hdr_d   = in_header;
                    dest_d  = dest_map;
                    state_d = WAIT_PAYLOAD;
                end
            end
            WAIT_PAYLOAD: state_d = IDLE;
            default:      state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hdr_q     <= '0;
            dest_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hdr_q   <= hdr_d;
            dest_q  <= dest_d;
            if (hdr_beat && !next_ready)
                overrun_q <= 1'b1;
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)
                count_q <= count_q + 1'b1;
            else if (pop && !push)
                count_q <= count_q - 1'b1;
        end
    end

    // Storage needs no reset: entries are only visible once count covers them.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            hdr_mem[wr_ptr_q] <= hdr_q;
            pay_mem[wr_ptr_q] <= in_payload;
            dst_mem[wr_ptr_q] <= dest_q;
        end
    end
endmodule

// File: tb/tb_egress_dest_queue.sv
// Directed bench for egress_dest_queue: vector table plus fill, error-entry and reset-mid-capture sequences.
module tb_egress_dest_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic [95:0] in_header;
    logic [2:0]  in_dest;
    logic [31:0] in_payload;
    logic        next_ready, out_valid;
    logic [95:0] out_header;
    logic [31:0] out_payload;
    logic [1:0]  out_dest;
    logic [2:0]  out_link;
    logic [3:0]  dest_ready;
    logic [3:0]  fifo_count;
    logic        overrun;
    logic [7:0]  drop_count;

    int checks = 0;
    int errors = 0;

    egress_dest_queue #(.DEPTH(8), .LINK_NUMBER(0)) dut (
        .clk(clk), .rst(rst), .in_header(in_header), .in_dest(in_dest),
        .in_payload(in_payload), .next_ready(next_ready), .out_valid(out_valid),
        .out_header(out_header), .out_payload(out_payload), .out_dest(out_dest),
        .out_link(out_link), .dest_ready(dest_ready), .fifo_count(fifo_count),
        .overrun(overrun), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [95:0] hdr;
        logic [2:0]  dest;
        logic [31:0] pay;
        logic [3:0]  dr;
        logic        ev;
        logic [95:0] eh;
        logic [31:0] ep;
        logic [1:0]  ed;
        logic [3:0]  ec;
        logic        enr;
    } vec_t;

    vec_t vt [15];

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [95:0] h, input logic [2:0] d, input logic [31:0] p);
        in_header = h;
        in_dest   = d;
        step();
        in_header  = '0;
        in_dest    = '0;
        in_payload = p;
        step();
        in_payload = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        vt[0]  = '{96'h1, 3'd2, 32'h0,        4'b0100, 1'b0, 96'h0, 32'h0,        2'd0, 4'd0, 1'b0};
        vt[1]  = '{96'h0, 3'd0, 32'hDEADBEEF, 4'b0100, 1'b1, 96'h1, 32'hDEADBEEF, 2'd2, 4'd1, 1'b1};
        vt[2]  = '{96'h0, 3'd0, 32'h0,        4'b0100, 1'b0, 96'h0, 32'h0,        2'd0, 4'd0, 1'b1};
        vt[3]  = '{96'hA, 3'd1, 32'h0,        4'b1000, 1'b0, 96'h0, 32'h0,        2'd0, 4'd0, 1'b0};
        vt[4]  = '{96'h0, 3'd0, 32'h11111111, 4'b1000, 1'b1, 96'hA, 32'h11111111, 2'd1, 4'd1, 1'b1};
        vt[5]  = '{96'hB, 3'd3, 32'h0,        4'b1000, 1'b1, 96'hA, 32'h11111111, 2'd1, 4'd1, 1'b0};
        vt[6]  = '{96'h0, 3'd0, 32'h22222222, 4'b1000, 1'b1, 96'hA, 32'h11111111, 2'd1, 4'd2, 1'b1};
        vt[7]  = '{96'h0, 3'd0, 32'h0,        4'b1000, 1'b1, 96'hA, 32'h11111111, 2'd1, 4'd2, 1'b1};
        vt[8]  = '{96'h0, 3'd0, 32'h0,        4'b1010, 1'b1, 96'hB, 32'h22222222, 2'd3, 4'd1, 1'b1};
        vt[9]  = '{96'h0, 3'd0, 32'h0,        4'b1010, 1'b0, 96'h0, 32'h0,        2'd0, 4'd0, 1'b1};
        vt[10] = '{96'hC, 3'd2, 32'h0,        4'b0000, 1'b0, 96'h0, 32'h0,        2'd0, 4'd0, 1'b0};
        vt[11] = '{96'h0, 3'd0, 32'h33,       4'b0000, 1'b1, 96'hC, 32'h33,       2'd2, 4'd1, 1'b1};
        vt[12] = '{96'hD, 3'd2, 32'h0,        4'b0000, 1'b1, 96'hC, 32'h33,       2'd2, 4'd1, 1'b0};
        vt[13] = '{96'h0, 3'd0, 32'h44,       4'b0100, 1'b1, 96'hD, 32'h44,       2'd2, 4'd1, 1'b1};
        vt[14] = '{96'h0, 3'd0, 32'h0,        4'b0100, 1'b0, 96'h0, 32'h0,        2'd0, 4'd0, 1'b1};

        // Reset with busy inputs
        rst = 1'b1; in_header = 96'hFFF; in_dest = 3'd2; in_payload = 32'hABC; dest_ready = 4'hF;
        step();
        step();
        check("rst_valid", out_valid, 1'b0);
        check("rst_hdr", out_header, 96'h0);
        check("rst_pay", out_payload, 32'h0);
        check("rst_dest", out_dest, 2'd0);
        check("rst_count", fifo_count, 4'd0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_drop", drop_count, 8'd0);
        check("rst_link", out_link, 3'd0);
        check("rst_nr", next_ready, 1'b1);
        in_header = '0; in_dest = '0; in_payload = '0; dest_ready = '0;
        rst = 1'b0;
        step();
        check("post_rst_nr", next_ready, 1'b1);

        // Table: single entry, head-of-line blocking, simultaneous push/pop
        for (int i = 0; i < 15; i++) begin
            in_header  = vt[i].hdr;
            in_dest    = vt[i].dest;
            in_payload = vt[i].pay;
            dest_ready = vt[i].dr;
            step();
            check($sformatf("v%0d_valid", i), out_valid, vt[i].ev);
            check($sformatf("v%0d_hdr", i), out_header, vt[i].eh);
            check($sformatf("v%0d_pay", i), out_payload, vt[i].ep);
            check($sformatf("v%0d_dest", i), out_dest, vt[i].ed);
            check($sformatf("v%0d_count", i), fifo_count, vt[i].ec);
            check($sformatf("v%0d_nr", i), next_ready, vt[i].enr);
        end
        in_header = '0; in_dest = '0; in_payload = '0; dest_ready = '0;

        // Fill to DEPTH, then back-pressure and overrun
        for (int i = 0; i < 8; i++)
            send(96'h100 + 96'(i), 3'd2, 32'h5000 + 32'(i));
        check("full_count", fifo_count, 4'd8);
        check("full_nr", next_ready, 1'b0);
        check("pre_overrun", overrun, 1'b0);
        in_header = 96'h999; in_dest = 3'd1;
        step();
        in_header = '0; in_dest = '0;
        check("overrun_set", overrun, 1'b1);
        check("overrun_count", fifo_count, 4'd8);
        dest_ready = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain%0d_hdr", i), out_header, 96'h100 + 96'(i));
            check($sformatf("drain%0d_pay", i), out_payload, 32'h5000 + 32'(i));
            step();
            if (i == 0) begin
                check("first_pop_nr", next_ready, 1'b1);
                check("first_pop_count", fifo_count, 4'd7);
            end
        end
        check("drained_count", fifo_count, 4'd0);
        check("overrun_sticky", overrun, 1'b1);
        dest_ready = '0;
        do_reset();
        check("overrun_clear", overrun, 1'b0);

        // Error-sink entries
`ifdef EGRESS_ERR_DROP_EN
        send(96'hE, 3'b101, 32'h55);
        check("drop_count1", fifo_count, 4'd0);
        check("drop_cnt1", drop_count, 8'd1);
        check("drop_nr", next_ready, 1'b1);
        for (int i = 0; i < 299; i++)
            send(96'hE, 3'd0, 32'h55);
        check("drop_sat", drop_count, 8'd255);
        check("drop_sat_count", fifo_count, 4'd0);
`else
        send(96'hE, 3'b101, 32'h55);
        check("err_valid", out_valid, 1'b1);
        check("err_dest", out_dest, 2'd0);
        check("err_hdr", out_header, 96'hE);
        check("err_pay", out_payload, 32'h55);
        check("err_drop", drop_count, 8'd0);
        dest_ready = 4'b0001;
        step();
        check("err_popped", fifo_count, 4'd0);
        dest_ready = '0;
`endif

        // Reset during WAIT_PAYLOAD discards the partial entry
        in_header = 96'h77; in_dest = 3'd3;
        step();
        check("mid_nr_low", next_ready, 1'b0);
        in_header = '0; in_dest = '0; in_payload = 32'h77;
        rst = 1'b1;
        step();
        rst = 1'b0; in_payload = '0;
        check("mid_count", fifo_count, 4'd0);
        check("mid_valid", out_valid, 1'b0);
        check("mid_nr", next_ready, 1'b1);
        send(96'h88, 3'd3, 32'h8888);
        check("mid_next_valid", out_valid, 1'b1);
        check("mid_next_hdr", out_header, 96'h88);
        check("mid_next_pay", out_payload, 32'h8888);
        check("mid_next_dest", out_dest, 2'd3);
        check("mid_next_count", fifo_count, 4'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
